aes_serial_host: RTL

AES_SERIAL_HOST -- requirements
Module: aes_serial_host

---
 rtl/aes_serial_host.sv | 130 +++++++++++++
 1 files changed

// File: rtl/aes_serial_host.sv
// Host-side sequencer for a byte-serial AES-128 core. It takes a key/plaintext
// request, resets the core, streams 16 key/data bytes MSB-first, then collects 16 ciphertext bytes.
module aes_serial_host #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_key,
    input  logic [127:0] req_data,
    output logic         core_rst,
    output logic [7:0]   key_in,
    output logic [7:0]   d_in,
    input  logic [7:0]   d_out,
    input  logic         d_vld,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CRST = 3'd1;
    localparam logic [2:0] LOAD = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] CAPT = 3'd4;
    localparam logic [2:0] RESP = 3'd5;

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [127:0]  key_sr;
    logic [127:0]  data_sr;
    logic [127:0]  res;
    logic [3:0]    cnt;
    logic [TW-1:0] tmo;
    logic          err;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req_valid && req_ready) state_nx = CRST;
            CRST: state_nx = LOAD;
            LOAD: if (cnt == 4'd15) state_nx = WAIT;
            WAIT: begin
                if (d_vld)
                    state_nx = CAPT;
                else if (tmo <= TW'(1))
                    state_nx = RESP;
            end
            CAPT: if (cnt == 4'd15) state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // req_ready and core_rst are registered from the next state so that
    // both hold their reset values until the first edge with rst_n high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            core_rst  <= 1'b1;
            key_sr    <= '0;
            data_sr   <= '0;
            res       <= '0;
            cnt       <= '0;
            tmo       <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            req_ready <= (state_nx == IDLE);
            core_rst  <= (state_nx == CRST);
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        key_sr  <= req_key;
                        data_sr <= req_data;
                        res     <= '0;
                        err     <= 1'b0;
                    end
                end
                CRST: cnt <= '0;
                LOAD: begin
                    key_sr  <= {key_sr[119:0], 8'h00};
                    data_sr <= {data_sr[119:0], 8'h00};
                    if (cnt == 4'd15) begin
                        cnt <= '0;
                        tmo <= TMO_LOAD;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WAIT: begin
                    // A valid byte wins over an expiring timeout on the same edge.
                    if (d_vld) begin
                        res <= {res[119:0], d_out};
                        cnt <= 4'd1;
                        tmo <= '0;
                    end else if (tmo <= TW'(1)) begin
                        res <= '0;
                        err <= 1'b1;
                        tmo <= '0;
                    end else begin
                        tmo <= tmo - TW'(1);
                    end
                end
                CAPT: begin
                    res <= {res[119:0], d_out};
                    if (cnt == 4'd15)
                        cnt <= '0;
                    else
                        cnt <= cnt + 4'd1;
                end
                RESP: if (rsp_ready) err <= 1'b0;
                default: ;
            endcase
        end
    end

    assign key_in    = (state == LOAD) ? key_sr[127:120]  : 8'h00;
    assign d_in      = (state == LOAD) ? data_sr[127:120] : 8'h00;
    assign rsp_valid = (state == RESP);
    assign rsp_data  = res;
    assign rsp_err   = err;

endmodule
